// File: rtl/spi_master.sv
// spi_master: parametrised SPI master with runtime CPOL/CPHA, fixed SCK divider,
// configurable word width, MSB/LSB-first order and multiple active-low chip selects.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             transfer request, accepted only when idle
//   cpol, cpha        SPI mode, latched on accept
//   lsb_first         bit order, latched on accept
//   cs_sel            chip-select index, latched on accept (out of range selects none)
//   tx_data           word to send, latched on accept
//   rx_data           last received word, updated with done
//   busy              high while a transfer is in progress
//   done              one-cycle pulse when a transfer completes
//   sck, mosi, miso   SPI serial interface
//   cs_n              active-low chip selects
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NUM_CS  = 1,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic                cpol_q;
  logic                cpha_q;
  logic                lsb_q;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;

  logic div_last;
  logic last_edge;
  logic leading;
  logic sample_edge;
  logic drive_edge;
  logic tx_head;

  // Edge bookkeeping: edge_cnt holds the zero-based index of the next SCK edge,
  // so an even count means the upcoming edge is a leading one.
  assign div_last    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge   = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
  assign leading     = ~edge_cnt[0];
  assign sample_edge = cpha_q ? ~leading : leading;
  // With CPHA=0 the first bit goes out on accept, so the final trailing edge drives nothing.
  assign drive_edge  = cpha_q ? leading : (~leading & ~last_edge);
  assign tx_head     = lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (div_last) state_nxt = XFER;
      XFER:    if (div_last && last_edge) state_nxt = HOLD;
      HOLD:    if (div_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          edge_cnt <= '0;
          sck      <= cpol_q;
          if (start) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            sck    <= cpol;
            rx_sr  <= '0;
            for (int i = 0; i < NUM_CS; i++) begin
              cs_n[i] <= (cs_sel != CS_W'(i));
            end
            if (cpha) begin
              tx_sr <= tx_data;
            end else begin
              mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
              tx_sr <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end
          end
        end
        SETUP: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
        end
        XFER: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
          if (div_last) begin
            sck      <= ~sck;
            edge_cnt <= last_edge ? '0 : edge_cnt + EDGE_W'(1);
            if (sample_edge) begin
              rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
            end
            if (drive_edge) begin
              mosi  <= tx_head;
              tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
            end
          end
        end
        HOLD: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
          sck     <= cpol_q;
          if (div_last) begin
            cs_n    <= '1;
            rx_data <= rx_sr;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
